// File: rtl/data_memory_mc.sv
// -----------------------------------------------------------------------------
// data_memory_mc
//
// Multi-cycle, byte-strobed data memory. A request is taken on the
// req_valid/req_ready handshake. The access happens LATENCY edges later, and
// the result is signalled with a one-cycle resp_valid pulse. Every word is
// cleared while reset is high.
//
// Ports
//   clk         in   1             clock; all state changes on the rising edge
//   reset       in   1             synchronous, active-high
//   req_valid   in   1             request present
//   req_ready   out  1             block can accept a request (IDLE, not reset)
//   req_write   in   1             1 = write, 0 = read
//   req_addr    in   32            byte address; word index is
//                                  addr[OFF+IDX-1:OFF], other bits are ignored
//   req_wdata   in   DATA_WIDTH    write data
//   req_wstrb   in   DATA_WIDTH/8  byte write enables (bit i -> bits 8i+7:8i)
//   resp_valid  out  1             one-cycle response pulse (reads and writes)
//   resp_rdata  out  DATA_WIDTH    read data; held until the next read or reset
// -----------------------------------------------------------------------------
module data_memory_mc #(
    parameter int MEM_DEPTH  = 16384,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX   = $clog2(MEM_DEPTH);
    // A latency of 1 still needs a one-bit counter, which only ever holds 0.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_accept;
    logic                    w_access;

    // Request fields captured at acceptance. The inputs may change afterwards.
    logic                    r_write;
    logic [IDX-1:0]          r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NB-1:0]           r_wstrb;

    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic [IDX-1:0]          w_idx;

    // Word index taken from the byte address. High bits alias and low
    // (byte-offset) bits are dropped.
    assign w_idx = req_addr[OFF+IDX-1:OFF];

    // The handshake and response flags are gated combinationally by reset.
    // This keeps both flags low in every cycle in which reset is high, even
    // before the first reset edge has been seen.
    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign resp_valid = (r_state == S_RESP) && !reset;
    assign resp_rdata = r_rdata;

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, pulse in RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                // req_valid is deliberately ignored while busy.
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_idx   <= w_idx;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end else begin
            r_write <= r_write;
            r_idx   <= r_idx;
            r_wdata <= r_wdata;
            r_wstrb <= r_wstrb;
        end
    end

    // Storage array. It is zero-cleared during reset and byte-merged on writes.
    // Because reset takes priority, a request pending at reset never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_access && r_write) begin
            for (int b = 0; b < NB; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read-data register. Only a read access updates it, so writes leave it held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_access && !r_write) begin
            r_rdata <= r_mem[r_idx];
        end else begin
            r_rdata <= r_rdata;
        end
    end

endmodule

// File: doc/data_memory_mc.md
# data_memory_mc

Multi-cycle, byte-strobed data memory with a valid/ready request channel and a one-cycle response pulse. It replaces the single-cycle data memory in the multi-cycle and cache-equipped CPUs, where a realistic main-memory access latency is required. Width, depth and latency are parameters. Contents are zero-cleared on reset.

## Interface
- MEM_DEPTH, 16384, number of words; power of two, ≥ 2
- DATA_WIDTH, 32, word width in bits; multiple of 8
- LATENCY, 4, cycles from request acceptance to response; ≥ 1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  DATA_WIDTH/8  byte write enables; bit i covers bits [8i+7:8i]
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  read data; held between responses

## Operation
- Word index = req_addr[OFF+IDX-1:OFF].
  - OFF = log2(DATA_WIDTH/8).
  - IDX = log2(MEM_DEPTH).
  - Remaining high and low address bits are ignored; out-of-range addresses alias.
- FSM states:
  - IDLE: req_ready=1. On req_valid && req_ready, capture req_write, index, req_wdata and req_wstrb; load cnt = LATENCY-1; go to BUSY.
  - BUSY: req_ready=0; req_valid is ignored. If cnt≠0, decrement cnt. If cnt=0, perform the access and go to RESP.
  - RESP: req_ready=0, resp_valid=1; next state is IDLE.
- Access is performed at the BUSY edge where cnt=0.
  - Read: resp_rdata ← mem[index].
  - Write: for each i with wstrb[i]=1, byte i of mem[index] ← byte i of wdata. resp_rdata is unchanged.
  - Write with wstrb all zero: no memory change, but the response is still issued.
- Responses are issued for both reads and writes.
- Captured request fields are used for the whole access. Request inputs may change freely after acceptance.
- A read accepted after a write's response returns the written data.

## Timing
- Reset: while reset=1 at an edge:
  - state ← IDLE, cnt ← 0, resp_rdata ← 0.
  - Every memory word ← 0.
  - req_ready=0 and resp_valid=0 during any cycle with reset high.
- Reset mid-operation (BUSY or RESP): the pending request is dropped. No write occurs and no response is issued.
- Latency: acceptance at edge k gives access and resp_valid=1 in the cycle after edge k+LATENCY, for exactly one cycle.
- req_ready rises after edge k+LATENCY+1.
- Throughput: one request per LATENCY+2 cycles, back to back.
- LATENCY=1: BUSY lasts one cycle; response is visible after edge k+1.
- resp_rdata keeps its value until the next read access or reset.
- cnt width = max(1, clog2(LATENCY)).

## Test plan
- Reset clear: assert reset 1 cycle, then read addr 0x0000_0000 and 0x0000_FFFC → both return 0x0000_0000. req_ready=0 during reset, 1 after.
- Read latency (LATENCY=4): write 0xDEADBEEF to 0x40 with wstrb=4'hF, then read 0x40 accepted at edge k → resp_valid high only after edge k+4, rdata=0xDEADBEEF, req_ready high again after edge k+5.
- Byte strobes: write 0xAABBCCDD (wstrb=F), then 0x00001100 with wstrb=4'b0010, then 0x77000000 with wstrb=4'b1000 → read returns 0x77BB11DD. wstrb=0 write → contents unchanged, response still issued.
- Busy protocol: hold req_valid=1 with a write to 0x80 during BUSY/RESP of a prior read → not accepted until req_ready=1. Change req_addr one cycle after acceptance → access uses the captured address.
- Reset mid-operation: accept write 0x12345678 to 0x10, assert reset 2 cycles later → no resp_valid, and a subsequent read of 0x10 returns 0.
- Parameter sweep: LATENCY=1, DATA_WIDTH=64, MEM_DEPTH=256 → response one edge after acceptance. Address 0x800 aliases to 0x000. Byte strobe bit 7 writes bits [63:56] only.
